// File: rtl/cpu_test_pkg.sv
// Shared definitions for the CPU test sequencer: sequencer state encoding,
// default sizes and the memory-port widths used by CPUTop.
package cpu_test_pkg;

    // Tester-port widths matching CPUTop's memories
    localparam int unsigned CPU_ADDR_W       = 16;
    localparam int unsigned CPU_DATA_W       = 32;

    // Default sequence sizes
    localparam int unsigned DEF_PROG_WORDS   = 256;
    localparam int unsigned DEF_DATA_WORDS   = 256;
    localparam int unsigned DEF_DUMP_WORDS   = 256;
    localparam int unsigned DEF_STEP_MAX     = 20000;
    localparam int unsigned DEF_CNT_W        = 32;

    // Sequencer phases, in the order a full sequence visits them
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_PROG = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_RUN       = 3'd3,
        ST_DUMP_RD   = 3'd4,
        ST_DUMP_CAP  = 3'd5,
        ST_DUMP_OUT  = 3'd6
    } seq_state_e;

endpackage

// File: rtl/cpu_test_sequencer.sv
// Harness controller for CPUTop: loads program and data memories from a host
// word stream, runs the CPU until done or a cycle budget expires, then streams
// a window of data memory back to the host.
module cpu_test_sequencer
    import cpu_test_pkg::*;
#(
    parameter int unsigned ADDR_W     = CPU_ADDR_W,
    parameter int unsigned DATA_W     = CPU_DATA_W,
    parameter int unsigned PROG_WORDS = DEF_PROG_WORDS,
    parameter int unsigned DATA_WORDS = DEF_DATA_WORDS,
    parameter int unsigned DUMP_WORDS = DEF_DUMP_WORDS,
    parameter int unsigned STEP_MAX   = DEF_STEP_MAX,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              cpu_run,
    input  logic              cpu_done,
    output logic              prog_en,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_wdata,
    output logic              data_en,
    output logic              data_we,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              busy,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles
);

    // Word counts must be non-zero and addressable by the counter, and the
    // step budget must be representable by the cycle counter.
    if (PROG_WORDS == 0 || 64'(PROG_WORDS) > (64'd1 << ADDR_W)) begin : g_bad_prog
        $error("cpu_test_sequencer: PROG_WORDS out of range for ADDR_W");
    end
    if (DATA_WORDS == 0 || 64'(DATA_WORDS) > (64'd1 << ADDR_W)) begin : g_bad_data
        $error("cpu_test_sequencer: DATA_WORDS out of range for ADDR_W");
    end
    if (DUMP_WORDS == 0 || 64'(DUMP_WORDS) > (64'd1 << ADDR_W)) begin : g_bad_dump
        $error("cpu_test_sequencer: DUMP_WORDS out of range for ADDR_W");
    end
    if (STEP_MAX == 0 || (CNT_W < 32 && 64'(STEP_MAX) > (64'd1 << CNT_W))) begin : g_bad_step
        $error("cpu_test_sequencer: STEP_MAX out of range for CNT_W");
    end

    // Terminal counter values for each phase
    localparam logic [ADDR_W-1:0] PROG_LAST = ADDR_W'(PROG_WORDS - 1);
    localparam logic [ADDR_W-1:0] DATA_LAST = ADDR_W'(DATA_WORDS - 1);
    localparam logic [ADDR_W-1:0] DUMP_LAST = ADDR_W'(DUMP_WORDS - 1);
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_MAX - 1);

    // State and datapath registers
    seq_state_e        state_q,    state_d;
    logic [ADDR_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0]  cycles_q,   cycles_d;
    logic              timeout_q,  timeout_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    // Combinational port drivers
    logic              in_ready_s;
    logic              out_valid_s;
    logic              cpu_run_s;
    logic              prog_en_s;
    logic              prog_we_s;
    logic [ADDR_W-1:0] prog_addr_s;
    logic [DATA_W-1:0] prog_wdata_s;
    logic              data_en_s;
    logic              data_we_s;
    logic [ADDR_W-1:0] data_addr_s;
    logic [DATA_W-1:0] data_wdata_s;

    // Next-state, counter updates and memory/handshake outputs for each phase
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cycles_d     = cycles_q;
        timeout_d    = timeout_q;
        out_data_d   = out_data_q;
        in_ready_s   = 1'b0;
        out_valid_s  = 1'b0;
        cpu_run_s    = 1'b0;
        prog_en_s    = 1'b0;
        prog_we_s    = 1'b0;
        prog_addr_s  = {ADDR_W{1'b0}};
        prog_wdata_s = {DATA_W{1'b0}};
        data_en_s    = 1'b0;
        data_we_s    = 1'b0;
        data_addr_s  = {ADDR_W{1'b0}};
        data_wdata_s = {DATA_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                // Results of the previous sequence stay visible until a new start
                if (start) begin
                    state_d   = ST_LOAD_PROG;
                    cnt_d     = {ADDR_W{1'b0}};
                    cycles_d  = {CNT_W{1'b0}};
                    timeout_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_LOAD_PROG: begin
                in_ready_s   = 1'b1;
                prog_addr_s  = cnt_q;
                prog_wdata_s = in_data;
                if (in_valid) begin
                    prog_en_s = 1'b1;
                    prog_we_s = 1'b1;
                    if (cnt_q == PROG_LAST) begin
                        cnt_d   = {ADDR_W{1'b0}};
                        state_d = ST_LOAD_DATA;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_LOAD_DATA: begin
                in_ready_s   = 1'b1;
                data_addr_s  = cnt_q;
                data_wdata_s = in_data;
                if (in_valid) begin
                    data_en_s = 1'b1;
                    data_we_s = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = {ADDR_W{1'b0}};
                        state_d = ST_RUN;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_RUN: begin
                // The CPU owns both memories here; every run cycle is counted,
                // including the one in which done is seen. Done beats the budget.
                cpu_run_s = 1'b1;
                cycles_d  = cycles_q + CNT_W'(1);
                if (cpu_done) begin
                    timeout_d = 1'b0;
                    state_d   = ST_DUMP_RD;
                end else if (cycles_q == STEP_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DUMP_RD;
                end else begin
                    state_d   = ST_RUN;
                end
            end

            ST_DUMP_RD: begin
                data_en_s   = 1'b1;
                data_addr_s = cnt_q;
                state_d     = ST_DUMP_CAP;
            end

            ST_DUMP_CAP: begin
                // Read data arrives one cycle after the DUMP_RD request
                out_data_d = data_rdata;
                state_d    = ST_DUMP_OUT;
            end

            ST_DUMP_OUT: begin
                out_valid_s = 1'b1;
                if (out_ready) begin
                    if (cnt_q == DUMP_LAST) begin
                        cnt_d   = {ADDR_W{1'b0}};
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = ST_DUMP_RD;
                    end
                end else begin
                    state_d = ST_DUMP_OUT;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, counters and result registers; reset abandons any sequence
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {ADDR_W{1'b0}};
            cycles_q   <= {CNT_W{1'b0}};
            timeout_q  <= 1'b0;
            out_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cycles_q   <= cycles_d;
            timeout_q  <= timeout_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign out_data   = out_data_q;
    assign cpu_run    = cpu_run_s;
    assign prog_en    = prog_en_s;
    assign prog_we    = prog_we_s;
    assign prog_addr  = prog_addr_s;
    assign prog_wdata = prog_wdata_s;
    assign data_en    = data_en_s;
    assign data_we    = data_we_s;
    assign data_addr  = data_addr_s;
    assign data_wdata = data_wdata_s;
    assign busy       = (state_q != ST_IDLE);
    assign timeout    = timeout_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Scoreboard bench for cpu_test_sequencer with a small sequence geometry:
// 4 program words, 2 data words, 2 dump words, 10-cycle step budget.
module tb_cpu_test_sequencer;
    import cpu_test_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic          cpu_run;
    logic          cpu_done = 1'b0;
    logic          prog_en, prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_wdata;
    logic          data_en, data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata = '0;
    logic          busy, timeout;
    logic [CW-1:0] cycles;

    cpu_test_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .PROG_WORDS(4), .DATA_WORDS(2),
        .DUMP_WORDS(2), .STEP_MAX(10), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cpu_run(cpu_run), .cpu_done(cpu_done),
        .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .data_en(data_en), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .busy(busy), .timeout(timeout), .cycles(cycles)
    );

    always #5 clock = ~clock;

    // Data memory model: synchronous read, one-cycle latency, returns addr*3+1
    always @(posedge clock) begin
        if (data_en && !data_we) data_rdata <= {16'd0, data_addr} * 32'd3 + 32'd1;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_prog[$];
    wr_t           exp_data[$];
    logic [DW-1:0] exp_dump[$];
    int            tests = 0;
    int            fails = 0;
    int            dump_hs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes / dump words whenever the DUT presents them
    always @(negedge clock) begin
        wr_t e;
        if (!reset) begin
            if (prog_en) begin
                check("prog_write_expected", 64'(exp_prog.size() != 0), 64'(1));
                if (exp_prog.size() != 0) begin
                    e = exp_prog.pop_front();
                    check("prog_we", 64'(prog_we), 64'(1));
                    check("prog_addr", 64'(prog_addr), 64'(e.addr));
                    check("prog_wdata", 64'(prog_wdata), 64'(e.data));
                end
            end
            if (data_en && data_we) begin
                check("data_write_expected", 64'(exp_data.size() != 0), 64'(1));
                if (exp_data.size() != 0) begin
                    e = exp_data.pop_front();
                    check("data_addr", 64'(data_addr), 64'(e.addr));
                    check("data_wdata", 64'(data_wdata), 64'(e.data));
                end
            end
            if (cpu_run) check("run_enables_off", 64'({prog_en, data_en}), 64'(0));
            if (out_valid && out_ready) begin
                dump_hs++;
                check("dump_expected", 64'(exp_dump.size() != 0), 64'(1));
                if (exp_dump.size() != 0) check("dump_data", 64'(out_data), 64'(exp_dump.pop_front()));
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 64'({in_ready, out_valid, cpu_run, prog_en, prog_we,
                                  data_en, data_we, busy, timeout}), 64'(0));
        check({name, "_addr"}, 64'({prog_addr, data_addr}), 64'(0));
        check({name, "_pwdata"}, 64'(prog_wdata), 64'(0));
        check({name, "_dwdata"}, 64'(data_wdata), 64'(0));
        check({name, "_out_data"}, 64'(out_data), 64'(0));
        check({name, "_cycles"}, 64'(cycles), 64'(0));
    endtask

    task automatic start_seq();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        check("cycles_cleared", 64'(cycles), 64'(0));
        check("timeout_cleared", 64'(timeout), 64'(0));
    endtask

    // Streams words base..base+5; with gaps, an idle cycle follows each accept
    task automatic load_words(input logic [DW-1:0] base, input bit gaps);
        int i;
        for (int k = 0; k < 4; k++) exp_prog.push_back('{addr: AW'(k), data: base + DW'(k)});
        for (int k = 0; k < 2; k++) exp_data.push_back('{addr: AW'(k), data: base + DW'(4 + k)});
        i = 0;
        while (i < 6) begin
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            @(negedge clock);
            check("load_in_ready", 64'(in_ready), 64'(1));
            check("load_run_low", 64'(cpu_run), 64'(0));
            @(posedge clock); #1;
            i++;
            if (gaps && i < 6) begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
                @(negedge clock);
                check("gap_no_write", 64'({prog_en, data_en}), 64'(0));
                @(posedge clock); #1;
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("run_rise", 64'(cpu_run), 64'(1));
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(posedge clock); #1;
            n++;
        end
        check("idle_reached", 64'(busy), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_cnt;
        int n;
        int hs0;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Load back-to-back, done in the 5th run cycle
        exp_dump.push_back(32'h1);
        exp_dump.push_back(32'h4);
        start_seq();
        load_words(32'h11, 1'b0);
        repeat (4) begin @(posedge clock); #1; end
        cpu_done = 1'b1;
        @(posedge clock); #1;
        cpu_done = 1'b0;
        check("done_run_low", 64'(cpu_run), 64'(0));
        check("done_cycles", 64'(cycles), 64'(5));
        check("done_timeout", 64'(timeout), 64'(0));
        wait_idle(40);
        check("done_cycles_held", 64'(cycles), 64'(5));
        check("dump1_drained", 64'(exp_dump.size()), 64'(0));

        // Timeout, then a dump with word 0 stalled for 4 cycles
        start_seq();
        load_words(32'h41, 1'b0);
        out_ready = 1'b0;
        run_cnt = 0;
        while (cpu_run && run_cnt < 50) begin
            run_cnt++;
            @(posedge clock); #1;
        end
        check("timeout_run_len", 64'(run_cnt), 64'(10));
        check("timeout_flag", 64'(timeout), 64'(1));
        check("timeout_cycles", 64'(cycles), 64'(10));
        exp_dump.push_back(32'h1);
        exp_dump.push_back(32'h4);
        hs0 = dump_hs;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        repeat (4) begin
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_data", 64'(out_data), 64'(1));
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        wait_idle(40);
        check("dump_handshakes", 64'(dump_hs - hs0), 64'(2));
        check("timeout_held", 64'(timeout), 64'(1));

        // Done coincides with the 10th run cycle: done wins
        exp_dump.push_back(32'h1);
        exp_dump.push_back(32'h4);
        start_seq();
        load_words(32'h51, 1'b0);
        repeat (9) begin @(posedge clock); #1; end
        cpu_done = 1'b1;
        @(posedge clock); #1;
        cpu_done = 1'b0;
        check("corner_timeout", 64'(timeout), 64'(0));
        check("corner_cycles", 64'(cycles), 64'(10));
        check("corner_run_low", 64'(cpu_run), 64'(0));
        wait_idle(40);

        // Gapped load keeps addresses contiguous; done in first run cycle
        exp_dump.push_back(32'h1);
        exp_dump.push_back(32'h4);
        start_seq();
        load_words(32'h21, 1'b1);
        cpu_done = 1'b1;
        @(posedge clock); #1;
        cpu_done = 1'b0;
        check("gap_cycles", 64'(cycles), 64'(1));
        wait_idle(40);

        // Reset after two program writes, then a full reload from address 0
        start_seq();
        exp_prog.push_back('{addr: AW'(0), data: 32'h61});
        exp_prog.push_back('{addr: AW'(1), data: 32'h62});
        in_valid = 1'b1;
        in_data  = 32'h61;
        @(posedge clock); #1;
        in_data  = 32'h62;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_data  = '0;
        reset    = 1'b1;
        @(posedge clock); #1;
        check_all_zero("mid_reset");
        reset = 1'b0;
        check("partial_writes_seen", 64'(exp_prog.size()), 64'(0));
        exp_dump.push_back(32'h1);
        exp_dump.push_back(32'h4);
        start_seq();
        load_words(32'h71, 1'b0);
        cpu_done = 1'b1;
        @(posedge clock); #1;
        cpu_done = 1'b0;
        wait_idle(40);

        check("final_prog_q", 64'(exp_prog.size()), 64'(0));
        check("final_data_q", 64'(exp_data.size()), 64'(0));
        check("final_dump_q", 64'(exp_dump.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
